// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable frame format, 3-sample majority
// voting, glitch rejection, and a show-ahead receive FIFO with per-word error flags.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 57600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        rx_pin,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
  localparam int WORD_W       = DATA_BITS + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP0     = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP1     = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP2     = CNT_W'(HALF + 1);
  localparam logic             ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, rxs_q, rxsPrev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             smp_q, smp_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic                   resolve, vote, push;
  logic [WORD_W-1:0]      pushWord;

  logic [WORD_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wrPtr_q, rdPtr_q;
  logic [PTR_W:0]         count_q, count_d;
  logic                   overrun_q;
  logic                   full, empty, pop, doPush, drop;
  logic [WORD_W-1:0]      head;

  assign resolve  = (cnt_q == SMP2);
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign pushWord = {shift_q, perr_q, ferr_q | ~vote};

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxsPrev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_pin;
      rxs_q     <= sync1_q;
      rxsPrev_q <= rxs_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // The bit counter free-runs modulo CLKS_PER_BIT once a frame starts, so every
  // later bit resolves exactly one bit period after the start-bit vote.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == SMP0) smp_d[0] = rxs_q;
      if (cnt_q == SMP1) smp_d[1] = rxs_q;
    end
    case (state_q)
      S_IDLE: begin
        if (rxsPrev_q && !rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (resolve) begin
          state_d = vote ? S_IDLE : S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (resolve) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (resolve) begin
          perr_d  = vote != (^shift_q ^ ODD);
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (resolve) begin
          ferr_d = ferr_q | ~vote;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = !empty && rx_ready;
  assign doPush = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (doPush && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !doPush) count_d = count_q - (PTR_W+1)'(1);
  end

  // A drop in the same cycle as a clear leaves overrun set.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)    rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop)             overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem_q[wrPtr_q] <= pushWord;
  end

  assign head       = mem_q[rdPtr_q];
  assign rx_valid   = !empty;
  assign rx_data    = rx_valid ? head[WORD_W-1:2] : '0;
  assign rx_perr    = rx_valid ? head[1] : 1'b0;
  assign rx_ferr    = rx_valid ? head[0] : 1'b0;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: two instances (8N1 and 7E2) at 16 clocks per bit.
module tb_uart_rx_fifo;
  localparam int BAUD   = 57600;
  localparam int CPB    = 16;
  localparam int CLK_HZ = BAUD * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxPinA, rxReadyA, overrunClrA;
  logic [7:0] rxDataA;
  logic       rxPerrA, rxFerrA, rxValidA, overrunA, busyA;
  logic [2:0] fifoCountA;
  logic       rxPinB, rxReadyB, overrunClrB;
  logic [6:0] rxDataB;
  logic       rxPerrB, rxFerrB, rxValidB, overrunB, busyB;
  logic [2:0] fifoCountB;

  int checks = 0;
  int errors = 0;
  int latency;
  logic [7:0] expWords [4];

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
    .CLK(clock), .reset(reset), .rx_pin(rxPinA), .rx_data(rxDataA),
    .rx_perr(rxPerrA), .rx_ferr(rxFerrA), .rx_valid(rxValidA), .rx_ready(rxReadyA),
    .overrun(overrunA), .overrun_clr(overrunClrA), .busy(busyA), .fifo_count(fifoCountA)
  );

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dutB (
    .CLK(clock), .reset(reset), .rx_pin(rxPinB), .rx_data(rxDataB),
    .rx_perr(rxPerrB), .rx_ferr(rxFerrB), .rx_valid(rxValidB), .rx_ready(rxReadyB),
    .overrun(overrunB), .overrun_clr(overrunClrB), .busy(busyB), .fifo_count(fifoCountB)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pinA, input logic pinB, input int cycles);
    rxPinA = pinA;
    rxPinB = pinB;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic sendFrameA(input logic [7:0] data, input logic stopVal, input int spikeBit);
    applyStimulus(1'b0, 1'b1, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == spikeBit) begin
        applyStimulus(data[i], 1'b1, 9);
        applyStimulus(~data[i], 1'b1, 1);
        applyStimulus(data[i], 1'b1, CPB - 10);
      end else begin
        applyStimulus(data[i], 1'b1, CPB);
      end
    end
    applyStimulus(stopVal, 1'b1, CPB);
    rxPinA = 1'b1;
  endtask

  task automatic sendFrameB(input logic [6:0] data, input logic parityBit, input logic stop2);
    applyStimulus(1'b1, 1'b0, CPB);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, data[i], CPB);
    applyStimulus(1'b1, parityBit, CPB);
    applyStimulus(1'b1, 1'b1, CPB);
    applyStimulus(1'b1, stop2, CPB);
    rxPinB = 1'b1;
  endtask

  task automatic popA();
    rxReadyA = 1'b1;
    @(posedge clock);
    #1;
    rxReadyA = 1'b0;
  endtask

  task automatic popB();
    rxReadyB = 1'b1;
    @(posedge clock);
    #1;
    rxReadyB = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rxPinA = 1'b1; rxReadyA = 1'b0; overrunClrA = 1'b0;
    rxPinB = 1'b1; rxReadyB = 1'b0; overrunClrB = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_valid", 32'(rxValidA), 0);
    checkOutput("rst_count", 32'(fifoCountA), 0);
    checkOutput("rst_overrun", 32'(overrunA), 0);
    checkOutput("rst_busy", 32'(busyA), 0);
    checkOutput("rst_data", 32'(rxDataA), 0);
    checkOutput("rst_flags", 32'({rxPerrA, rxFerrA}), 0);
    applyStimulus(1'b1, 1'b1, 5);

    // Single 0xF4 frame with the consumer always ready: the stop bit resolves
    // 13 edges into the stop bit, so rx_valid is seen high then for one cycle.
    rxReadyA = 1'b1;
    applyStimulus(1'b0, 1'b1, CPB);
    for (int i = 0; i < 8; i++) applyStimulus(((8'hF4 >> i) & 8'h01) != 0, 1'b1, CPB);
    rxPinA = 1'b1;
    latency = 0;
    while (!rxValidA && latency < 40) begin
      @(posedge clock);
      #1;
      latency++;
    end
    checkOutput("f4_latency", 32'(latency), 13);
    checkOutput("f4_data", 32'(rxDataA), 'hF4);
    checkOutput("f4_flags", 32'({rxPerrA, rxFerrA}), 0);
    checkOutput("f4_busy", 32'(busyA), 0);
    @(posedge clock);
    #1;
    checkOutput("f4_pulse", 32'(rxValidA), 0);
    checkOutput("f4_count", 32'(fifoCountA), 0);
    rxReadyA = 1'b0;
    applyStimulus(1'b1, 1'b1, 10);

    // Six back-to-back frames into a four-deep FIFO with nobody reading.
    sendFrameA(8'hF4, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    sendFrameA(8'h7E, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    sendFrameA(8'h03, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    sendFrameA(8'h55, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    sendFrameA(8'h57, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    sendFrameA(8'h41, 1'b1, -1); applyStimulus(1'b1, 1'b1, 10);
    checkOutput("ovf_count", 32'(fifoCountA), 4);
    checkOutput("ovf_flag", 32'(overrunA), 1);
    overrunClrA = 1'b1;
    @(posedge clock);
    #1;
    overrunClrA = 1'b0;
    checkOutput("ovf_clear", 32'(overrunA), 0);
    expWords[0] = 8'hF4; expWords[1] = 8'h7E; expWords[2] = 8'h03; expWords[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_valid", 32'(rxValidA), 1);
      checkOutput("ovf_data", 32'(rxDataA), 32'(expWords[i]));
      popA();
    end
    checkOutput("ovf_empty", 32'(rxValidA), 0);
    checkOutput("ovf_count0", 32'(fifoCountA), 0);
    checkOutput("ovf_flag0", 32'(overrunA), 0);

    // Short low pulse is rejected at the start-bit vote.
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("glitch_busy", 32'(busyA), 1);
    applyStimulus(1'b1, 1'b1, 30);
    checkOutput("glitch_idle", 32'(busyA), 0);
    checkOutput("glitch_count", 32'(fifoCountA), 0);

    // One-cycle spikes at a data-bit sample point are outvoted.
    sendFrameA(8'h00, 1'b1, 3); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("spike0_count", 32'(fifoCountA), 1);
    checkOutput("spike0_data", 32'(rxDataA), 'h00);
    popA();
    sendFrameA(8'hFF, 1'b1, 5); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("spike1_data", 32'(rxDataA), 'hFF);
    checkOutput("spike1_ferr", 32'(rxFerrA), 0);
    popA();

    // Low stop bit: word kept with ferr, no phantom frame, next frame clean.
    sendFrameA(8'h41, 1'b0, -1); applyStimulus(1'b1, 1'b1, 40);
    checkOutput("ferr_count", 32'(fifoCountA), 1);
    checkOutput("ferr_data", 32'(rxDataA), 'h41);
    checkOutput("ferr_flags", 32'({rxPerrA, rxFerrA}), 'b01);
    popA();
    sendFrameA(8'h7E, 1'b1, -1); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("after_ferr_data", 32'(rxDataA), 'h7E);
    checkOutput("after_ferr_flags", 32'({rxPerrA, rxFerrA}), 0);
    popA();

    // 7E2: 0x55 has four ones, so the even parity bit is 0.
    sendFrameB(7'h55, 1'b0, 1'b1); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("par_ok_valid", 32'(rxValidB), 1);
    checkOutput("par_ok_data", 32'(rxDataB), 'h55);
    checkOutput("par_ok_flags", 32'({rxPerrB, rxFerrB}), 0);
    popB();
    sendFrameB(7'h55, 1'b1, 1'b1); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("par_bad_data", 32'(rxDataB), 'h55);
    checkOutput("par_bad_flags", 32'({rxPerrB, rxFerrB}), 'b10);
    popB();
    sendFrameB(7'h2A, 1'b1, 1'b0); applyStimulus(1'b1, 1'b1, 30);
    checkOutput("stop2_data", 32'(rxDataB), 'h2A);
    checkOutput("stop2_flags", 32'({rxPerrB, rxFerrB}), 'b01);
    popB();
    checkOutput("b_empty", 32'(fifoCountB), 0);

    // Reset in the middle of data bit 3 of 0xA5 (line low) aborts the frame.
    applyStimulus(1'b0, 1'b1, CPB);
    for (int i = 0; i < 3; i++) applyStimulus(((8'hA5 >> i) & 8'h01) != 0, 1'b1, CPB);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("mid_busy", 32'(busyA), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rxPinA = 1'b1;
    checkOutput("abort_busy", 32'(busyA), 0);
    checkOutput("abort_count", 32'(fifoCountA), 0);
    applyStimulus(1'b1, 1'b1, 200);
    checkOutput("abort_later", 32'(fifoCountA), 0);
    sendFrameA(8'h03, 1'b1, -1); applyStimulus(1'b1, 1'b1, 5);
    checkOutput("post_rst_count", 32'(fifoCountA), 1);
    checkOutput("post_rst_data", 32'(rxDataA), 'h03);
    checkOutput("post_rst_flags", 32'({rxPerrA, rxFerrA}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receive path feeding the shift-register and LED logic on the Atlys board. It adds configurable frame format (data bits, parity, stop bits), 3-sample majority voting and glitch rejection. Received words go into a small FIFO with a valid/ready read port, carrying per-word parity/framing error flags and a sticky overrun flag. It sits between the board RX pin and the downstream consumer.

Parameters:
CLK_HZ, 100000000, system clock frequency
BAUD, 57600, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (1736 at defaults)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries; power of two, minimum 2

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high
rx_pin  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  FIFO head data
rx_perr  out  1  FIFO head parity error flag (always 0 when PARITY=0)
rx_ferr  out  1  FIFO head framing error flag
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pops the head when rx_valid && rx_ready at a rising edge
overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
overrun_clr  in  1  clears overrun
busy  out  1  receiver FSM is not in IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous and active-high.
- Reset values: both synchronizer flops = 1, FSM = IDLE, FIFO empty, rx_valid = 0, fifo_count = 0, overrun = 0, busy = 0, rx_data/rx_perr/rx_ferr = 0. Reset asserted mid-frame aborts the frame; no partial word is written.
- Input synchronizer: rx_pin passes through 2 flops to give rxs. All logic uses rxs; this adds 2 cycles of latency.
- Majority sample: taken at bit-counter values HALF-1, HALF and HALF+1, where HALF = CLKS_PER_BIT/2. The bit value is the majority of the three samples and is resolved at HALF+1.
- FSM:
  - IDLE: a 1→0 transition on rxs → START; the bit counter is cleared.
  - START: counter runs to the majority point. If the voted value is 1 → IDLE (glitch rejected, nothing written). If 0 → DATA, with the counter realigned so that subsequent samples fall CLKS_PER_BIT apart.
  - DATA: shift in DATA_BITS bits, LSB first. Then → PARITY if PARITY≠0, else → STOP.
  - PARITY: sample one bit. perr = (received parity ≠ computed parity), where odd parity means data plus parity bit has an odd count of 1s. → STOP.
  - STOP: sample STOP_BITS bits. ferr = 1 if any sampled stop bit = 0.
  - After the final stop sample: write {data, perr, ferr} into the FIFO in that same cycle and go → IDLE. The next start-edge search begins immediately (mid-stop-bit), so back-to-back frames with zero idle time are supported.
- A framing-error frame is still written, with ferr = 1. If it ended with the line low, IDLE waits for rxs = 1 before accepting a new falling edge.
- Latency: rx_valid rises on the cycle after the final stop-bit majority resolves.
- FIFO:
  - Show-ahead: rx_data/rx_perr/rx_ferr reflect the head whenever rx_valid = 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when full: the pop frees a slot and the push succeeds; occupancy is unchanged.
  - Push while full with no pop: the word is dropped and overrun is set on the next cycle.
  - Pop while empty: ignored.
- overrun: if overrun_clr and a new overrun event occur in the same cycle, set wins.
- busy = (state ≠ IDLE).

Test Plan:
- Single frame 8N1, byte 0xF4 at 57600 baud (17360 ns/bit), rx_ready = 1 → rx_valid pulses for exactly 1 cycle with rx_data = 0xF4, perr = 0, ferr = 0. rx_valid rises 1 cycle after the stop majority point, about 9.5 bit periods plus 2 cycles after the start edge.
- Back-to-back frames 0xF4, 0x7E, 0x03, 0x55, 0x57, 0x41 with 100 ns gaps, rx_ready = 0, FIFO_DEPTH = 4 → fifo_count = 4 and overrun = 1. Then pulse overrun_clr and pop 4 words → data 0xF4, 0x7E, 0x03, 0x55 in order, overrun = 0, rx_valid = 0.
- Glitch rejection: rx_pin low for 500 cycles, then high → busy goes high then returns to 0, no write, fifo_count = 0. Also apply a 1-cycle high spike inside a data bit → the majority vote keeps the bit value.
- Framing error: 0x41 sent with stop bit = 0, then line held high → word 0x41 with ferr = 1; the next frame 0x7E is received correctly.
- PARITY = 2, DATA_BITS = 7: send 0x55 with a correct even parity bit → perr = 0; repeat with the parity bit flipped → perr = 1, data still 0x55.
- Reset during the 4th data bit of a frame → the FIFO stays empty and busy = 0 on the cycle after reset. A following full frame 0x03 is received correctly.
